// File: rtl/cu_sequencer_pkg.sv
// Shared definitions for the control-unit sequencer: control-word field
// positions, sequencer state codes, instruction classes and opcode encodings.
package cu_sequencer_pkg;

    localparam int unsigned CW_W   = 38;
    localparam int unsigned NS_W   = 3;
    localparam int unsigned ST_W   = 4;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned WD_W   = 3;

    // Control-word field positions (LSB of multi-bit fields)
    localparam int unsigned FS_LSB          = 33;
    localparam int unsigned SA_LSB          = 28;
    localparam int unsigned SB_LSB          = 23;
    localparam int unsigned DA_LSB          = 18;
    localparam int unsigned W_REG_BIT       = 17;
    localparam int unsigned C0_BIT          = 16;
    localparam int unsigned MEM_CS_LSB      = 14;
    localparam int unsigned B_SEL_BIT       = 13;
    localparam int unsigned MEM_W_BIT       = 12;
    localparam int unsigned IR_LOAD_BIT     = 11;
    localparam int unsigned STATUS_LOAD_BIT = 10;
    localparam int unsigned SIZE_LSB        = 8;
    localparam int unsigned ADD_TRI_BIT     = 7;
    localparam int unsigned DATA_TRI_BIT    = 6;
    localparam int unsigned PC_SEL_BIT      = 5;
    localparam int unsigned PC_FS_LSB       = 3;
    localparam int unsigned K_MUX_LSB       = 0;

    typedef enum logic [3:0] {
        ST_FETCH = 4'h0,
        ST_EX0   = 4'h8,
        ST_EX1   = 4'h9,
        ST_EX2   = 4'hA,
        ST_EX3   = 4'hB,
        ST_EX4   = 4'hC,
        ST_EX5   = 4'hD,
        ST_EX6   = 4'hE,
        ST_EX7   = 4'hF
    } state_e;

    typedef enum logic [2:0] {
        CLS_ILL = 3'd0,
        CLS_R   = 3'd1,
        CLS_I   = 3'd2,
        CLS_D   = 3'd3,
        CLS_B   = 3'd4
    } cls_e;

    // Branch / conditional-branch opcodes
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    // Data transfer
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    // Immediate
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
    localparam logic [9:0]  OP_SUBIS = 10'b1111000100;
    localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
    localparam logic [9:0]  OP_ANDIS = 10'b1111001000;
    localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
    localparam logic [9:0]  OP_EORI  = 10'b1101001000;
    // Register
    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ANDS  = 11'b11101010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_EOR   = 11'b11001010000;

endpackage

// File: rtl/cu_class_decode.sv
// Combinational instruction classifier; branch beats data-transfer beats
// immediate beats register, anything else is illegal.
module cu_class_decode
    import cu_sequencer_pkg::*;
(
    input  logic [31:0] instr,
    output cls_e        cls
);

    logic unused_bits;
    assign unused_bits = ^instr[20:0];

    always_comb begin
        cls = CLS_ILL;
        if (instr[31:26] == OP_B ||
            instr[31:24] inside {OP_CBZ, OP_CBNZ, OP_BCOND}) begin
            cls = CLS_B;
        end else if (instr[31:21] inside {OP_STUR, OP_LDUR}) begin
            cls = CLS_D;
        end else if (instr[31:22] inside {OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
                                          OP_ANDI, OP_ANDIS, OP_ORRI, OP_EORI}) begin
            cls = CLS_I;
        end else if (instr[31:21] inside {OP_ADD, OP_ADDS, OP_SUB, OP_SUBS,
                                          OP_AND, OP_ANDS, OP_ORR, OP_EOR}) begin
            cls = CLS_R;
        end
    end

endmodule

// File: rtl/cu_sequencer.sv
// Top-level sequencer: fetches an instruction, classifies it, then steps
// through the selected sub-CU's micro-sequence with stall and watchdog.
module cu_sequencer
    import cu_sequencer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instr_in,
    input  logic              instr_valid,
    input  logic              mem_ready,
    input  logic [FLAG_W-1:0] alu_status,
    input  logic [CW_W-1:0]   cw_r,
    input  logic [CW_W-1:0]   cw_i,
    input  logic [CW_W-1:0]   cw_d,
    input  logic [CW_W-1:0]   cw_b,
    input  logic [NS_W-1:0]   ns_r,
    input  logic [NS_W-1:0]   ns_i,
    input  logic [NS_W-1:0]   ns_d,
    input  logic [NS_W-1:0]   ns_b,
    output logic [10:0]       opcode,
    output logic [4:0]        SA,
    output logic [4:0]        SB,
    output logic [4:0]        DA,
    output logic [ST_W-1:0]   state,
    output logic [FLAG_W-1:0] status,
    output logic [CW_W-1:0]   controlWord,
    output logic              fetch_req,
    output logic              illegal
);

    state_e            state_q, state_d;
    cls_e              cls_q, cls_d, dec_cls;
    logic [31:0]       ir_q, ir_d;
    logic [FLAG_W-1:0] status_d;
    logic              illegal_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [NS_W-1:0]   ns_sel;
    logic              in_exec;
    logic              stall;

    cu_class_decode u_decode (
        .instr (instr_in),
        .cls   (dec_cls)
    );

    assign in_exec   = state_q[ST_W-1];
    assign opcode    = ir_q[31:21];
    assign SB        = ir_q[20:16];
    assign SA        = ir_q[9:5];
    assign DA        = ir_q[4:0];
    assign state     = state_q;
    assign fetch_req = (state_q == ST_FETCH);

    // Sub-CU select; an illegal class or a non-EXEC state drives a null word
    always_comb begin
        controlWord = '0;
        ns_sel      = '0;
        if (in_exec) begin
            case (cls_q)
                CLS_R:   begin controlWord = cw_r; ns_sel = ns_r; end
                CLS_I:   begin controlWord = cw_i; ns_sel = ns_i; end
                CLS_D:   begin controlWord = cw_d; ns_sel = ns_d; end
                CLS_B:   begin controlWord = cw_b; ns_sel = ns_b; end
                default: begin controlWord = '0;   ns_sel = '0;   end
            endcase
        end
    end

    assign stall = in_exec && (controlWord[MEM_CS_LSB +: 2] != 2'b00) && !mem_ready;

    // Next-state, IR, flag and watchdog logic
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        ir_d      = ir_q;
        status_d  = status;
        illegal_d = 1'b0;
        wd_d      = wd_q;
        case (state_q)
            ST_FETCH: begin
                wd_d = '0;
                if (instr_valid) begin
                    ir_d      = instr_in;
                    cls_d     = dec_cls;
                    state_d   = ST_EX0;
                    illegal_d = (dec_cls == CLS_ILL);
                end
            end
            ST_EX0, ST_EX1, ST_EX2, ST_EX3, ST_EX4, ST_EX5, ST_EX6, ST_EX7: begin
                if (cls_q == CLS_ILL) begin
                    state_d = ST_FETCH;
                    wd_d    = '0;
                end else if (!stall) begin
                    if (controlWord[STATUS_LOAD_BIT]) begin
                        status_d = alu_status;
                    end
                    if (ns_sel == '0) begin
                        state_d = ST_FETCH;
                        wd_d    = '0;
                    end else if (wd_q == WD_W'(7)) begin
                        // Eighth step without completing: abandon as illegal
                        state_d   = ST_FETCH;
                        illegal_d = 1'b1;
                        wd_d      = '0;
                    end else begin
                        state_d = state_e'({1'b1, ns_sel});
                        wd_d    = wd_q + WD_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_FETCH;
                wd_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            cls_q   <= CLS_ILL;
            ir_q    <= '0;
            status  <= '0;
            illegal <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            ir_q    <= ir_d;
            status  <= status_d;
            illegal <= illegal_d;
            wd_q    <= wd_d;
        end
    end

endmodule
